// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
// Shared definitions for the HI/LO multiply/divide sequencer:
//   - default operand and iteration-counter widths
//   - mul/div operation encodings as presented on op_i
//   - sequencer state encoding
//   - small helpers that decode an operation code
// -----------------------------------------------------------------------------
package md_pkg;

   localparam int MD_DATA_W = 32;
   localparam int MD_CNT_W  = 6;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

   // Signed variants are MULT and DIV.
   function automatic logic is_signed_op(input logic [1:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

   // Divide variants are DIV and DIVU.
   function automatic logic is_div_op(input logic [1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_step.sv
// -----------------------------------------------------------------------------
// md_step
// Combinational single iteration of the radix-2 multiply/divide core.
// Ports:
//   div_i  : 0 = shift-add multiply step, 1 = restoring shift-subtract step
//   acc_i  : accumulator (product high half / partial remainder)
//   sr_i   : shift register (multiplier -> product low half /
//            dividend -> quotient)
//   opnd_i : multiplicand (multiply) or divisor (divide) magnitude
//   acc_o  : next accumulator
//   sr_o   : next shift register
// -----------------------------------------------------------------------------
module md_step #(
   parameter int DATA_W = 32
) (
   input  logic              div_i,
   input  logic [DATA_W-1:0] acc_i,
   input  logic [DATA_W-1:0] sr_i,
   input  logic [DATA_W-1:0] opnd_i,
   output logic [DATA_W-1:0] acc_o,
   output logic [DATA_W-1:0] sr_o
);

   logic [DATA_W:0] addend;    // acc plus optional multiplicand, with carry
   logic [DATA_W:0] shifted;   // partial remainder after shifting in a dividend bit
   logic [DATA_W:0] rem_sub;   // shifted minus divisor
   logic            fits;      // divisor fits: quotient bit is 1

   always_comb begin
      addend  = sr_i[0] ? ({1'b0, acc_i} + {1'b0, opnd_i}) : {1'b0, acc_i};
      shifted = {acc_i, sr_i[DATA_W-1]};
      fits    = (shifted >= {1'b0, opnd_i});
      rem_sub = shifted - {1'b0, opnd_i};

      if (div_i) begin
         // The partial remainder is always below the divisor, so the kept
         // value fits back into DATA_W bits whichever branch is taken.
         acc_o = DATA_W'(fits ? rem_sub : shifted);
         sr_o  = {sr_i[DATA_W-2:0], fits};
      end else begin
         // Shift {carry, acc, sr} right by one; the bit leaving acc becomes
         // the next product bit at the top of sr.
         acc_o = addend[DATA_W:1];
         sr_o  = {addend[0], sr_i[DATA_W-1:1]};
      end
   end

endmodule

// File: rtl/hilo_md_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_md_ctrl
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
// Runs 32 radix-2 iterations on operand magnitudes, applies sign correction,
// commits the result to HI/LO and stalls the front of the pipeline meanwhile.
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   start_i  : EX holds a mul/div instruction
//   op_i     : 0=MULT 1=MULTU 2=DIV 3=DIVU
//   src_a_i  : rs value (multiplicand / dividend, MTHI/MTLO data)
//   src_b_i  : rt value (multiplier / divisor)
//   mthi_i   : write src_a_i to HI (idle only)
//   mtlo_i   : write src_a_i to LO (idle only)
//   flush_i  : cancel in-flight operation
//   stall_o  : freeze PC, IF/ID, ID/EX
//   done_o   : one-cycle pulse after HI/LO commit
//   hi_o     : HI register
//   lo_o     : LO register
// -----------------------------------------------------------------------------
module hilo_md_ctrl
   import md_pkg::*;
#(
   parameter int DATA_W = MD_DATA_W,
   parameter int CNT_W  = MD_CNT_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [1:0]        op_i,
   input  logic [DATA_W-1:0] src_a_i,
   input  logic [DATA_W-1:0] src_b_i,
   input  logic              mthi_i,
   input  logic              mtlo_i,
   input  logic              flush_i,
   output logic              stall_o,
   output logic              done_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   md_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              div_q, div_d;
   logic              neg_res_q, neg_res_d;   // negate product / quotient
   logic              neg_rem_q, neg_rem_d;   // negate remainder
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] sr_q, sr_d;
   logic [DATA_W-1:0] opnd_q, opnd_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;

   logic [DATA_W-1:0] step_acc, step_sr;

   md_step #(.DATA_W(DATA_W)) u_step (
      .div_i  (div_q),
      .acc_i  (acc_q),
      .sr_i   (sr_q),
      .opnd_i (opnd_q),
      .acc_o  (step_acc),
      .sr_o   (step_sr)
   );

   // Operand magnitudes; the core itself is purely unsigned.
   logic              sgn_op;
   logic [DATA_W-1:0] mag_a, mag_b;
   assign sgn_op = is_signed_op(op_i);
   assign mag_a  = (sgn_op && src_a_i[DATA_W-1]) ? -src_a_i : src_a_i;
   assign mag_b  = (sgn_op && src_b_i[DATA_W-1]) ? -src_b_i : src_b_i;

   // Sign fix-up. 0x80000000 / -1 needs no special case: the magnitude
   // quotient 0x80000000 negates to itself and the remainder is zero.
   logic [2*DATA_W-1:0] prod_mag, prod_fix;
   logic [DATA_W-1:0]   quo_fix, rem_fix;
   assign prod_mag = {acc_q, sr_q};
   assign prod_fix = neg_res_q ? -prod_mag : prod_mag;
   assign quo_fix  = neg_res_q ? -sr_q : sr_q;
   assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      acc_d     = acc_q;
      sr_d      = sr_q;
      opnd_d    = opnd_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i && !flush_i) begin
               div_d     = is_div_op(op_i);
               neg_res_d = sgn_op && (src_a_i[DATA_W-1] ^ src_b_i[DATA_W-1]);
               neg_rem_d = sgn_op && src_a_i[DATA_W-1];
               acc_d     = '0;
               sr_d      = mag_a;
               opnd_d    = mag_b;
               cnt_d     = '0;
               // Divide by zero skips the core and leaves HI/LO untouched.
               if (is_div_op(op_i) && (src_b_i == '0)) state_d = ST_DONE;
               else                                    state_d = ST_CALC;
            end else begin
               if (mthi_i) hi_d = src_a_i;
               if (mtlo_i) lo_d = src_a_i;
            end
         end

         ST_CALC: begin
            if (flush_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               acc_d = step_acc;
               sr_d  = step_sr;
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  state_d = ST_FIX;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         ST_FIX: begin
            if (flush_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
               if (div_q) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else begin
                  hi_d = prod_fix[2*DATA_W-1:DATA_W];
                  lo_d = prod_fix[DATA_W-1:0];
               end
            end
         end

         ST_DONE: begin
            // The instruction is leaving EX; a start seen now is not new work.
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         div_q     <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         acc_q     <= '0;
         sr_q      <= '0;
         opnd_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         acc_q     <= acc_d;
         sr_q      <= sr_d;
         opnd_q    <= opnd_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign stall_o = ((state_q == ST_IDLE) && start_i) ||
                    (state_q == ST_CALC) || (state_q == ST_FIX);
   assign done_o  = (state_q == ST_DONE);
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_md_ctrl
// Directed and randomized checks of the HI/LO multiply/divide sequencer
// against a reference model built on plain 64-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_hilo_md_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a, src_b;
   logic        mthi, mtlo, flush;
   logic        stall, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_hi, exp_lo;

   hilo_md_ctrl dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .start_i (start),
      .op_i    (op),
      .src_a_i (src_a),
      .src_b_i (src_b),
      .mthi_i  (mthi),
      .mtlo_i  (mtlo),
      .flush_i (flush),
      .stall_o (stall),
      .done_o  (done),
      .hi_o    (hi),
      .lo_o    (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference: signed results from sign-extended 64-bit arithmetic, with
   // truncating division (remainder follows the dividend sign).
   task automatic model_op(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
      logic        sgn;
      logic [63:0] ea, eb, p;
      longint      q, r;
      sgn = (mop == 2'd0) || (mop == 2'd2);
      ea  = sgn ? {{32{a[31]}}, a} : {32'd0, a};
      eb  = sgn ? {{32{b[31]}}, b} : {32'd0, b};
      if (mop < 2'd2) begin
         p      = ea * eb;
         exp_hi = p[63:32];
         exp_lo = p[31:0];
      end else if (b != 32'd0) begin
         q      = $signed(ea) / $signed(eb);
         r      = $signed(ea) % $signed(eb);
         exp_lo = 32'(q);
         exp_hi = 32'(r);
      end
   endtask

   // Issue one operation at cycle 0 (we are just after a rising edge).
   // flush_cyc / mt_cyc < 0 disable those injections.
   task automatic run_op(input string tag, input logic [1:0] mop, input logic [31:0] a,
                         input logic [31:0] b, input int flush_cyc, input int mt_cyc);
      int cyc, stall_cnt, done_cyc, exp_done, exp_stall;
      cyc = 0; stall_cnt = 0; done_cyc = -1;
      if (flush_cyc >= 0) begin
         exp_done  = -1;
         exp_stall = flush_cyc + 1;
      end else if (mop >= 2'd2 && b == 32'd0) begin
         exp_done  = 1;
         exp_stall = 1;
      end else begin
         exp_done  = 34;
         exp_stall = 34;
      end
      if (flush_cyc < 0) model_op(mop, a, b);
      start = 1'b1; op = mop; src_a = a; src_b = b;
      while (cyc < 60 && done_cyc < 0) begin
         flush = (cyc == flush_cyc);
         mthi  = (cyc == mt_cyc);
         mtlo  = (cyc == mt_cyc);
         if (cyc == mt_cyc) src_a = 32'h5555_5555;
         #1;
         if (stall) stall_cnt++;
         if (done) done_cyc = cyc;
         @(posedge clk); #1;
         start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
         cyc++;
      end
      chk({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
      chk({tag, " stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
      chk({tag, " hi"}, hi, exp_hi);
      chk({tag, " lo"}, lo, exp_lo);
      $display("op=%0d a=%h b=%h flush@%0d -> hi=%h lo=%h done@%0d stall=%0d",
               mop, a, b, flush_cyc, hi, lo, done_cyc, stall_cnt);
   endtask

   task automatic mt_write(input logic to_hi, input logic [31:0] val);
      mthi = to_hi; mtlo = !to_hi; src_a = val;
      @(posedge clk); #1;
      mthi = 1'b0; mtlo = 1'b0;
      if (to_hi) exp_hi = val; else exp_lo = val;
      chk("mt hi", hi, exp_hi);
      chk("mt lo", lo, exp_lo);
      $display("mt%s %h -> hi=%h lo=%h", to_hi ? "hi" : "lo", val, hi, lo);
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      int          rfl;

      rst_n = 1'b0; start = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
      mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
      exp_hi = '0; exp_lo = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset stall", 32'(stall), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("mult neg", 2'd0, 32'hFFFF_FFFD, 32'd5, -1, -1);
      run_op("divu 100/7", 2'd3, 32'd100, 32'd7, -1, -1);
      run_op("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, -1, -1);
      run_op("div ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
      run_op("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);

      mt_write(1'b1, 32'h11);
      mt_write(1'b0, 32'h22);
      run_op("div by 0", 2'd2, 32'd1234, 32'd0, -1, -1);
      run_op("divu by 0", 2'd3, 32'hDEAD_BEEF, 32'd0, -1, -1);

      run_op("mult flush", 2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 10, -1);
      run_op("divu 9/3", 2'd3, 32'd9, 32'd3, -1, -1);

      mt_write(1'b1, 32'h0000_ABCD);
      run_op("mult mt busy", 2'd0, 32'h0001_0003, 32'hFFFF_0007, -1, 5);

      for (int i = 0; i < 24; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 255));
            2:       rb = -32'($urandom_range(1, 255));
            default: rb = $urandom;
         endcase
         rfl = -1;
         if (!(rop >= 2'd2 && rb == 32'd0) && ($urandom_range(0, 4) == 0))
            rfl = $urandom_range(1, 33);
         run_op("random", rop, ra, rb, rfl, -1);
      end

      // Asynchronous reset part-way through an operation.
      start = 1'b1; op = 2'd0; src_a = 32'hFFFF_FFFF; src_b = 32'h7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      exp_hi = '0; exp_lo = '0;
      chk("async rst stall", 32'(stall), 32'd0);
      chk("async rst done", 32'(done), 32'd0);
      chk("async rst hi", hi, exp_hi);
      chk("async rst lo", lo, exp_lo);
      $display("async reset mid-op -> hi=%h lo=%h stall=%0d", hi, lo, stall);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post rst stall", 32'(stall), 32'd0);
      mt_write(1'b1, 32'h0000_ABCD);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
